// File: rtl/freq_seg_display.sv
// Converts each new 34-bit frequency word to BCD (sequential double-dabble), auto-ranges to Hz/kHz
// and drives two time-multiplexed 4-digit 7-segment groups.
module freq_seg_display #(
  parameter int unsigned SCAN_CNT_MAX = 100_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [33:0] freq,
  output logic [7:0]  an,
  output logic [7:0]  seg1,
  output logic [7:0]  seg0,
  output logic        unit_khz,
  output logic        busy
);

  localparam int unsigned FREQ_W  = 34;
  localparam int unsigned BCD_N   = 11;
  localparam int unsigned DISP_N  = 8;
  localparam int unsigned ITER_W  = 6;
  localparam int unsigned SCAN_W  = (SCAN_CNT_MAX > 0) ? $clog2(SCAN_CNT_MAX + 1) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(FREQ_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CNT_MAX);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                      state, state_n;
  logic [FREQ_W-1:0]           s1, s2, conv_last, bin;
  logic [BCD_N-1:0][3:0]       bcd, bcd_adj;
  logic [ITER_W-1:0]           iter;
  logic [DISP_N-1:0][3:0]      disp;
  logic [DISP_N-1:0]           blank;
  logic [SCAN_W-1:0]           scan_cnt;
  logic [1:0]                  slot;
  logic                        conv_start;
  logic                        nz_above;
  logic [2:0]                  lo_idx, hi_idx;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // A new value is accepted only once the synchroniser has settled on it.
  assign conv_start = (state == IDLE) && (s1 == s2) && (s2 != conv_last);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (conv_start) state_n = CONV;
      CONV:    if (iter == ITER_LAST) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy <= 1'b0;
      s1   <= '0;
      s2   <= '0;
    end else begin
      busy <= (state_n == CONV);
      s1   <= freq;
      s2   <= s1;
    end
  end

  // Add-3 correction on every nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < BCD_N; n++) begin
      if (bcd[n] >= 4'd5) bcd_adj[n] = bcd[n] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      conv_last <= '0;
      bin       <= '0;
      bcd       <= '0;
      iter      <= '0;
      disp      <= '0;
      unit_khz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (conv_start) begin
            conv_last <= s2;
            bin       <= s2;
            bcd       <= '0;
            iter      <= '0;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          iter       <= iter + ITER_W'(1);
        end
        LOAD: begin
          if (bcd[10:8] == '0) begin
            disp     <= bcd[7:0];
            unit_khz <= 1'b0;
          end else begin
            disp     <= bcd[10:3];
            unit_khz <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking; the rightmost digit always shows.
  always_comb begin
    blank    = '0;
    nz_above = 1'b0;
    for (int i = DISP_N - 1; i >= 1; i--) begin
      nz_above = nz_above | (disp[3'(i)] != 4'd0);
      blank[3'(i)] = ~nz_above;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      slot     <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      slot     <= slot + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign lo_idx = {1'b0, slot};
  assign hi_idx = {1'b1, slot};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      an   <= '0;
      seg0 <= '0;
      seg1 <= '0;
    end else begin
      an   <= 8'h11 << slot;
      seg0 <= blank[lo_idx] ? 8'h00 : seg_code(disp[lo_idx]);
      seg1 <= blank[hi_idx] ? 8'h00 : seg_code(disp[hi_idx]);
    end
  end

endmodule

// File: tb/tb_freq_seg_display.sv
// Bench for freq_seg_display: directed and random frequencies checked against a decimal model.
module tb_freq_seg_display;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [33:0] freq;
  logic [7:0]  an, seg1, seg0;
  logic        unit_khz, busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] code_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  freq_seg_display #(.SCAN_CNT_MAX(3)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .freq     (freq),
    .an       (an),
    .seg1     (seg1),
    .seg0     (seg0),
    .unit_khz (unit_khz),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: auto-range, split into digits, blank leading zeros.
  task automatic model(input logic [33:0] f, output logic [7:0] segs [8], output logic khz);
    longint v, shown, p;
    int d [8];
    int top;
    v     = longint'(f);
    khz   = (v >= 64'd100_000_000);
    shown = khz ? v / 1000 : v;
    p     = 1;
    top   = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'((shown / p) % 10);
      p    = p * 10;
      if (d[i] != 0) top = i;
    end
    for (int i = 0; i < 8; i++) segs[i] = (i > top) ? 8'h00 : code_tab[d[i]];
  endtask

  // Observe 16 cycles of scanning from a negedge and compare against the model.
  task automatic check_display(input logic [33:0] f);
    logic [7:0] segs [8];
    logic       khz;
    logic [7:0] hist [16];
    int         k;
    model(f, segs, khz);
    for (int t = 0; t < 16; t++) begin
      hist[t] = an;
      k = -1;
      for (int j = 0; j < 4; j++) if (an === (8'h11 << j)) k = j;
      check($sformatf("an_valid f=%0d", f), 64'(k >= 0), 64'd1);
      if (k >= 0) begin
        check($sformatf("seg0 f=%0d slot%0d", f, k), 64'(seg0), 64'(segs[k]));
        check($sformatf("seg1 f=%0d slot%0d", f, k), 64'(seg1), 64'(segs[k+4]));
      end
      check($sformatf("unit_khz f=%0d", f), 64'(unit_khz), 64'(khz));
      @(negedge sys_clk);
    end
    for (int t = 0; t < 12; t++)
      check($sformatf("an_rotate f=%0d t=%0d", f, t), 64'(hist[t+4]), 64'({hist[t][6:0], hist[t][7]}));
  endtask

  task automatic wait_busy_high();
    int c = 0;
    while (busy !== 1'b1 && c < 10) begin
      @(negedge sys_clk);
      c++;
    end
    check("busy_start", 64'(busy), 64'd1);
  endtask

  task automatic count_busy(input int already, output int n);
    n = already;
    while (busy === 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic conv_and_check(input logic [33:0] f);
    int n;
    wait_busy_high();
    count_busy(0, n);
    check($sformatf("busy_len f=%0d", f), 64'(n), 64'd34);
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_display(f);
  endtask

  initial begin
    logic [33:0] f, last;
    int          n;
    logic        seen;

    sys_rst_n = 1'b0;
    freq      = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_an", 64'(an), 64'h00);
    check("rst_seg0", 64'(seg0), 64'h00);
    check("rst_seg1", 64'(seg1), 64'h00);
    check("rst_khz", 64'(unit_khz), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("rel_an", 64'(an), 64'h11);
    check("rel_seg0", 64'(seg0), 64'h3F);
    check("rel_seg1", 64'(seg1), 64'h00);

    // Zero input must never start a conversion.
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= busy;
      @(negedge sys_clk);
    end
    check("zero_no_busy", 64'(seen), 64'd0);

    freq = 34'd12_345_678;   conv_and_check(freq);
    freq = 34'd5;            conv_and_check(freq);
    freq = 34'd123_456_789;  conv_and_check(freq);
    freq = 34'h3_FFFF_FFFF;  conv_and_check(freq);
    freq = 34'd99_999_999;   conv_and_check(freq);
    freq = 34'd100_000_000;  conv_and_check(freq);
    last = freq;

    for (int r = 0; r < 6; r++) begin
      f = {2'($urandom_range(0, 3)), 32'($urandom())} >> $urandom_range(0, 33);
      while (f == 34'd0 || f == last) f = f + 34'd1;
      freq = f;
      conv_and_check(f);
      last = f;
    end

    // A change during CONV is picked up only after the running conversion completes.
    freq = 34'd1000;
    wait_busy_high();
    repeat (9) @(negedge sys_clk);
    freq = 34'd2000;
    count_busy(9, n);
    check("busy_len_1000", 64'(n), 64'd34);
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_display(34'd1000);
    check("second_busy", 64'(busy), 64'd1);
    count_busy(0, n);
    check("second_busy_end", 64'(busy), 64'd0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_display(34'd2000);

    // Reset in the middle of a conversion.
    freq = 34'd777;
    wait_busy_high();
    repeat (19) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_an", 64'(an), 64'h00);
    check("midrst_seg0", 64'(seg0), 64'h00);
    check("midrst_seg1", 64'(seg1), 64'h00);
    check("midrst_khz", 64'(unit_khz), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("midrel_an", 64'(an), 64'h11);
    check("midrel_seg0", 64'(seg0), 64'h3F);
    check("midrel_seg1", 64'(seg1), 64'h00);
    conv_and_check(34'd777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
